// File: rtl/instruction_fetch_decode.sv
// instruction_fetch_decode: owns the instruction pointer, reads the
// combinational instruction memory, registers the returned word and presents
// its sliced fields to execute over a valid/ready handshake.
// Optional build macro JMP_FOLD_EN: unconditional jumps are resolved in fetch
// and never reach execute.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_BOOT  | first cycle after reset, nothing presented
// S_RUN   | normal fetch, one instruction per cycle while accepted
// S_FLUSH | one bubble after a redirect while the new IP reaches memory

`ifndef JMP
`define JMP 3'b010
`endif
`ifndef UNC
`define UNC 3'b000
`endif

module instruction_fetch_decode #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_IP = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              dec_ready,
  output logic              dec_valid,
  output logic [ADDR_W-1:0] dec_ip,
  output logic [2:0]        dec_opcode,
  output logic [2:0]        dec_subop,
  output logic              dec_a_is_reg,
  output logic [7:0]        dec_a,
  output logic              dec_b_is_reg,
  output logic [7:0]        dec_b,
  output logic [7:0]        dec_target,
  output logic              dec_is_nop
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ip_q, ip_d;
  logic [ADDR_W-1:0] dip_q, dip_d;
  logic [31:0]       word_q, word_d;
  logic              valid_q, valid_d;
  logic              advance;
`ifdef JMP_FOLD_EN
  logic              is_unc_jmp;
`endif

  // Next-state: redirect first, then boot/flush bubbles, then fetch or stall.
  always_comb begin
    state_d = state_q;
    ip_d    = ip_q;
    dip_d   = dip_q;
    word_d  = word_q;
    valid_d = valid_q;
    advance = !valid_q || dec_ready;
`ifdef JMP_FOLD_EN
    is_unc_jmp = (imem_data[31:29] == `JMP) && (imem_data[28:26] == `UNC);
`endif
    if (redirect_valid) begin
      // Presented instruction is dropped whether or not execute took it.
      ip_d    = redirect_addr;
      valid_d = 1'b0;
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_BOOT, S_FLUSH: begin
          valid_d = 1'b0;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (advance) begin
`ifdef JMP_FOLD_EN
            if (is_unc_jmp) begin
              ip_d    = ADDR_W'(imem_data[7:0]);
              valid_d = 1'b0;
            end else
`endif
            begin
              word_d  = imem_data;
              dip_d   = ip_q;
              valid_d = 1'b1;
              ip_d    = ip_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = S_BOOT;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      ip_q    <= RESET_IP;
      dip_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ip_q    <= ip_d;
      dip_q   <= dip_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  // Memory address tracks IP; decoded fields are plain slices of the held word.
  always_comb begin
    imem_addr    = ip_q;
    dec_valid    = valid_q;
    dec_ip       = dip_q;
    dec_opcode   = word_q[31:29];
    dec_subop    = word_q[28:26];
    dec_a_is_reg = word_q[25];
    dec_a        = word_q[24:17];
    dec_b_is_reg = word_q[16];
    dec_b        = word_q[15:8];
    dec_target   = word_q[7:0];
    dec_is_nop   = (word_q == 32'd0);
  end

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// Bench for instruction_fetch_decode: ROM model, directed scenarios from the
// feature list, then randomized traffic against a behavioural model.

`ifndef JMP
`define JMP 3'b010
`endif
`ifndef UNC
`define UNC 3'b000
`endif

module tb_instruction_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_addr = 8'd0;
  logic        dec_ready = 1'b0;
  logic        dec_valid;
  logic [7:0]  dec_ip;
  logic [2:0]  dec_opcode, dec_subop;
  logic        dec_a_is_reg, dec_b_is_reg, dec_is_nop;
  logic [7:0]  dec_a, dec_b, dec_target;
  logic [31:0] dec_word;

  logic [31:0] rom [256];

  int tests_run = 0;
  int tests_failed = 0;

  // behavioural model: where fetch will read next, what is presented, bubbles left
  logic [7:0]  m_ip = 8'd0;
  logic        m_valid = 1'b0;
  logic [31:0] m_word = 32'd0;
  logic [7:0]  m_dip = 8'd0;
  int          m_bub = 1;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr];
  assign dec_word  = {dec_opcode, dec_subop, dec_a_is_reg, dec_a, dec_b_is_reg, dec_b, dec_target};

  instruction_fetch_decode dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .dec_ready      (dec_ready),
    .dec_valid      (dec_valid),
    .dec_ip         (dec_ip),
    .dec_opcode     (dec_opcode),
    .dec_subop      (dec_subop),
    .dec_a_is_reg   (dec_a_is_reg),
    .dec_a          (dec_a),
    .dec_b_is_reg   (dec_b_is_reg),
    .dec_b          (dec_b),
    .dec_target     (dec_target),
    .dec_is_nop     (dec_is_nop)
  );

  task automatic tick();
    logic [31:0] w;
    @(posedge clk);
    if (!rst_n) begin
      m_ip = 8'd0; m_valid = 1'b0; m_word = 32'd0; m_dip = 8'd0; m_bub = 1;
    end else if (redirect_valid) begin
      m_ip = redirect_addr; m_valid = 1'b0; m_bub = 1;
    end else if (m_bub > 0) begin
      m_bub = m_bub - 1; m_valid = 1'b0;
    end else if (!m_valid || dec_ready) begin
      w = rom[m_ip];
`ifdef JMP_FOLD_EN
      if (w[31:29] == `JMP && w[28:26] == `UNC) begin
        m_ip = w[7:0]; m_valid = 1'b0;
      end else begin
        m_word = w; m_dip = m_ip; m_valid = 1'b1; m_ip = m_ip + 8'd1;
      end
`else
      m_word = w; m_dip = m_ip; m_valid = 1'b1; m_ip = m_ip + 8'd1;
`endif
    end
    #1;
  endtask

  task automatic load_rom();
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w[31:29] == `JMP && w[28:26] == `UNC) w[28:26] = w[28:26] ^ 3'b001;
      if (w == 32'd0) w = 32'h1234_5678;
      rom[i] = w;
    end
    rom[8] = 32'd0;
    rom[5] = {`JMP, `UNC, 1'b0, 8'h11, 1'b1, 8'h22, 8'd6};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_addr = 8'd77; dec_ready = 1'b1;
    tick(); tick();
    tests_run++;
    if (imem_addr !== 8'd0) begin tests_failed++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
    tests_run++;
    if (dec_valid !== 1'b0 || dec_ip !== 8'd0 || dec_word !== 32'd0) begin
      tests_failed++; $display("FAIL reset_fields got v=%b ip=%0d w=%h want 0", dec_valid, dec_ip, dec_word);
    end
    rst_n = 1'b1; redirect_valid = 1'b0;
    tick();
    tests_run++;
    if (dec_valid !== 1'b0 || imem_addr !== 8'd0) begin
      tests_failed++; $display("FAIL boot_cycle got v=%b addr=%0d want v=0 addr=0", dec_valid, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (dec_valid !== 1'b1 || dec_ip !== 8'(i) || dec_word !== rom[i]) begin
        tests_failed++;
        $display("FAIL seq_fetch got v=%b ip=%0d w=%h want v=1 ip=%0d w=%h", dec_valid, dec_ip, dec_word, i, rom[i]);
      end
    end
  endtask

  task automatic test_stall();
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (dec_valid !== 1'b1 || dec_ip !== 8'd3 || imem_addr !== 8'd4 || dec_word !== rom[3]) begin
        tests_failed++;
        $display("FAIL stall_hold got v=%b ip=%0d addr=%0d w=%h want v=1 ip=3 addr=4 w=%h",
                 dec_valid, dec_ip, imem_addr, dec_word, rom[3]);
      end
    end
    dec_ready = 1'b1;
    tick();
    tests_run++;
    if (dec_valid !== 1'b1 || dec_ip !== 8'd4) begin
      tests_failed++; $display("FAIL stall_release got v=%b ip=%0d want v=1 ip=4", dec_valid, dec_ip);
    end
  endtask

  task automatic test_jmp_fold();
    tick();
`ifdef JMP_FOLD_EN
    tests_run++;
    if (dec_valid !== 1'b0 || imem_addr !== 8'd6) begin
      tests_failed++; $display("FAIL fold_bubble got v=%b addr=%0d want v=0 addr=6", dec_valid, imem_addr);
    end
`else
    tests_run++;
    if (dec_valid !== 1'b1 || dec_ip !== 8'd5 || dec_opcode !== `JMP || dec_target !== 8'd6) begin
      tests_failed++;
      $display("FAIL jmp_presented got v=%b ip=%0d op=%0d tgt=%0d want v=1 ip=5 op=%0d tgt=6",
               dec_valid, dec_ip, dec_opcode, dec_target, `JMP);
    end
`endif
    tick();
    tests_run++;
    if (dec_valid !== 1'b1 || dec_ip !== 8'd6 || dec_word !== rom[6]) begin
      tests_failed++; $display("FAIL jmp_target got v=%b ip=%0d want v=1 ip=6", dec_valid, dec_ip);
    end
  endtask

  task automatic test_nop();
    tick(); tick();
    tests_run++;
    if (dec_valid !== 1'b1 || dec_ip !== 8'd8 || dec_is_nop !== 1'b1 || dec_word !== 32'd0) begin
      tests_failed++;
      $display("FAIL nop got v=%b ip=%0d nop=%b w=%h want v=1 ip=8 nop=1 w=0", dec_valid, dec_ip, dec_is_nop, dec_word);
    end
    tick(); tick();
    tests_run++;
    if (dec_ip !== 8'd10 || dec_is_nop !== 1'b0) begin
      tests_failed++; $display("FAIL after_nop got ip=%0d nop=%b want ip=10 nop=0", dec_ip, dec_is_nop);
    end
  endtask

  task automatic test_redirect();
    dec_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 8'd85;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (dec_valid !== 1'b0 || imem_addr !== 8'd85) begin
      tests_failed++; $display("FAIL redirect_drop got v=%b addr=%0d want v=0 addr=85", dec_valid, imem_addr);
    end
    tick();
    tests_run++;
    if (dec_valid !== 1'b0) begin tests_failed++; $display("FAIL redirect_flush got v=%b want 0", dec_valid); end
    tick();
    tests_run++;
    if (dec_valid !== 1'b1 || dec_ip !== 8'd85 || dec_word !== rom[85]) begin
      tests_failed++; $display("FAIL redirect_target got v=%b ip=%0d want v=1 ip=85", dec_valid, dec_ip);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_ip;
    dec_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 8'd254;
    tick();
    redirect_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_ip = 8'((254 + i) % 256);
      tests_run++;
      if (dec_valid !== 1'b1 || dec_ip !== exp_ip || dec_word !== rom[exp_ip]) begin
        tests_failed++; $display("FAIL wrap got v=%b ip=%0d want v=1 ip=%0d", dec_valid, dec_ip, exp_ip);
      end
    end
  endtask

  task automatic test_reset_vs_redirect();
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_addr = 8'd99;
    tick();
    tests_run++;
    if (imem_addr !== 8'd0 || dec_valid !== 1'b0 || dec_word !== 32'd0) begin
      tests_failed++; $display("FAIL reset_beats_redirect got addr=%0d v=%b want addr=0 v=0", imem_addr, dec_valid);
    end
    rst_n = 1'b1; redirect_valid = 1'b0;
    tick(); tick();
    tests_run++;
    if (dec_valid !== 1'b1 || dec_ip !== 8'd0) begin
      tests_failed++; $display("FAIL restart got v=%b ip=%0d want v=1 ip=0", dec_valid, dec_ip);
    end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1; redirect_addr = 8'd20;
    tick();
    redirect_addr = 8'd40;
    tick();
    redirect_valid = 1'b0;
    tick();
    tests_run++;
    if (dec_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_flush got v=%b want 0", dec_valid); end
    tick();
    tests_run++;
    if (dec_valid !== 1'b1 || dec_ip !== 8'd40) begin
      tests_failed++; $display("FAIL b2b_last_wins got v=%b ip=%0d want v=1 ip=40", dec_valid, dec_ip);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst_n          = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      redirect_valid = ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0;
      redirect_addr  = ($urandom_range(0, 3) == 0) ? 8'd5 : 8'($urandom);
      dec_ready      = ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0;
      tick();
      tests_run++;
      if (imem_addr !== m_ip || dec_valid !== m_valid) begin
        tests_failed++;
        $display("FAIL rand_ctrl cyc=%0d got addr=%0d v=%b want addr=%0d v=%b", n, imem_addr, dec_valid, m_ip, m_valid);
      end
      if (m_valid) begin
        tests_run++;
        if (dec_ip !== m_dip || dec_word !== m_word || dec_is_nop !== (m_word == 32'd0)) begin
          tests_failed++;
          $display("FAIL rand_fields cyc=%0d got ip=%0d w=%h nop=%b want ip=%0d w=%h",
                   n, dec_ip, dec_word, dec_is_nop, m_dip, m_word);
        end
      end
    end
    rst_n = 1'b1; redirect_valid = 1'b0;
  endtask

  initial begin
    load_rom();
    test_reset();
    test_stall();
    test_jmp_fold();
    test_nop();
    test_redirect();
    test_wrap();
    test_reset_vs_redirect();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
